game_move_engine: RTL and testbench

- Owns the 4x4 2048 board and is the stage directly upstream of the tile-lookup/render path; its matrix output drives that stage's matrix input.
- Accepts one debounced direction command at a time, then runs a multi-cycle FSM:
  - slides and merges the 16 tiles;
  - spawns a new tile from an LFSR;
  - updates score, win and lose.
- Also supports a direct board load for restart and verification.

---
 rtl/game_move_engine.sv | 252 +++++++++++++++++++++++++
 tb/tb_game_move_engine.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/game_move_engine.sv
`default_nettype none
// ============================================================================
// Module   : game_move_engine
// Purpose  : Owns the 4x4 2048 board. Accepts one direction command or one
//            board load at a time, then slides/merges the tiles line by line,
//            spawns a new tile from an LFSR and updates score, win and lose.
// Ports    : clk, rst_n (async, active low)
//            dir_valid/dir        - direction command (sampled when busy=0)
//            load_valid/load_matrix - board load (wins over dir_valid)
//            matrix               - board, cell(c,r) = matrix[16c+4r +: 4]
//            busy, done, moved    - handshake / status of the last command
//            score, win, lose     - game status
// Revision : 1.0 - initial release
// ============================================================================
module game_move_engine #(
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter logic [3:0]  WIN_EXP    = 4'd11,
  parameter int          INIT_TILES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dir_valid,
  input  logic [1:0]  dir,
  input  logic        load_valid,
  input  logic [63:0] load_matrix,
  output logic [63:0] matrix,
  output logic        busy,
  output logic        done,
  output logic        moved,
  output logic [19:0] score,
  output logic        win,
  output logic        lose
);

  localparam logic [2:0] c_S_INIT  = 3'd0;
  localparam logic [2:0] c_S_IDLE  = 3'd1;
  localparam logic [2:0] c_S_SLIDE = 3'd2;
  localparam logic [2:0] c_S_SPAWN = 3'd3;
  localparam logic [2:0] c_S_CHECK = 3'd4;

  localparam logic [1:0] c_DIR_UP   = 2'd0;
  localparam logic [1:0] c_DIR_DOWN = 2'd1;
  localparam logic [1:0] c_DIR_LEFT = 2'd2;

  logic [2:0]  r_state, w_next_state;
  logic [63:0] r_matrix;
  logic [15:0] r_lfsr;
  logic [19:0] r_score;
  logic        r_win, r_lose, r_done, r_moved, r_initing;
  logic [1:0]  r_dir, r_line;
  logic [3:0]  r_spawn_idx, r_spawn_cnt;
  logic [4:0]  r_init_left;

  logic [3:0]  w_cells [16];
  logic [3:0]  w_idx   [4];
  logic [3:0]  w_in    [4];
  logic [3:0]  w_cmp   [4];
  logic [3:0]  w_out   [4];
  logic [1:0]  w_p, w_q;
  logic        w_skip;
  logic [15:0] w_gain;
  logic        w_line_changed;
  logic [63:0] w_slide_matrix;
  logic [20:0] w_score_sum;
  logic [19:0] w_score_next;
  logic        w_has_zero, w_has_pair, w_has_win;
  logic        w_spawn_hit;
  logic [3:0]  w_spawn_val;
  logic        w_lfsr_fb;

  // Taps 16,14,13,11 of a left-shifting Fibonacci register.
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_comb begin
    for (int i = 0; i < 16; i++) w_cells[i] = r_matrix[4*i +: 4];
  end

  // Board status: empty cells, orthogonal equal neighbours, winning tile.
  // Cell index i = 4c+r, so i+1 is the next row and i+4 the next column.
  always_comb begin
    w_has_zero = 1'b0;
    w_has_pair = 1'b0;
    w_has_win  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (w_cells[i] == 4'd0) w_has_zero = 1'b1;
      if (w_cells[i] >= WIN_EXP) w_has_win = 1'b1;
      if ((i % 4) != 3 && w_cells[i] == w_cells[(i + 1) % 16]) w_has_pair = 1'b1;
      if (i < 12 && w_cells[i] == w_cells[(i + 4) % 16]) w_has_pair = 1'b1;
    end
  end

  // One line per SLIDE cycle: gather in leading-end order, compact, merge,
  // scatter back into a copy of the board.
  always_comb begin
    w_gain         = '0;
    w_line_changed = 1'b0;
    w_slide_matrix = r_matrix;
    w_p            = '0;
    w_q            = '0;
    w_skip         = 1'b0;
    for (int j = 0; j < 4; j++) begin
      case (r_dir)
        c_DIR_UP:   w_idx[j] = {r_line, 2'(j)};
        c_DIR_DOWN: w_idx[j] = {r_line, 2'(3 - j)};
        c_DIR_LEFT: w_idx[j] = {2'(j), r_line};
        default:    w_idx[j] = {2'(3 - j), r_line};
      endcase
      w_in[j]  = w_cells[w_idx[j]];
      w_cmp[j] = 4'd0;
      w_out[j] = 4'd0;
    end
    for (int j = 0; j < 4; j++) begin
      if (w_in[j] != 4'd0) begin
        w_cmp[w_p] = w_in[j];
        w_p = w_p + 2'd1;
      end
    end
    // Exponent 14 is the ceiling: merging it would yield the reserved 4'hF.
    for (int j = 0; j < 4; j++) begin
      if (w_skip) begin
        w_skip = 1'b0;
      end else if (w_cmp[j] != 4'd0) begin
        if (j < 3 && w_cmp[j] == w_cmp[(j + 1) % 4] && w_cmp[j] < 4'd14) begin
          w_out[w_q] = w_cmp[j] + 4'd1;
          w_gain     = w_gain + (16'd1 << (w_cmp[j] + 4'd1));
          w_skip     = 1'b1;
        end else begin
          w_out[w_q] = w_cmp[j];
        end
        w_q = w_q + 2'd1;
      end
    end
    for (int j = 0; j < 4; j++) begin
      if (w_out[j] != w_in[j]) w_line_changed = 1'b1;
      w_slide_matrix[{w_idx[j], 2'b00} +: 4] = w_out[j];
    end
  end

  assign w_score_sum  = {1'b0, r_score} + {5'd0, w_gain};
  assign w_score_next = w_score_sum[20] ? 20'hFFFFF : w_score_sum[19:0];
  assign w_spawn_hit  = (w_cells[r_spawn_idx] == 4'd0);
  assign w_spawn_val  = (r_lfsr[7:4] == 4'd0) ? 4'd2 : 4'd1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_S_INIT;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_S_INIT:  w_next_state = (r_init_left != 5'd0) ? c_S_SPAWN : c_S_CHECK;
      c_S_IDLE: begin
        if (load_valid)     w_next_state = c_S_CHECK;
        else if (dir_valid) w_next_state = c_S_SLIDE;
      end
      c_S_SLIDE: begin
        if (r_line == 2'd3)
          w_next_state = (r_moved | w_line_changed) ? c_S_SPAWN : c_S_CHECK;
      end
      // The cycle bound only matters if a full board ever reaches SPAWN.
      c_S_SPAWN: begin
        if (w_spawn_hit || r_spawn_cnt == 4'd15)
          w_next_state = r_initing ? c_S_INIT : c_S_CHECK;
      end
      c_S_CHECK: w_next_state = c_S_IDLE;
      default:   w_next_state = c_S_INIT;
    endcase
  end

  // Outputs
  always_comb begin
    busy   = (r_state != c_S_IDLE);
    done   = r_done;
    moved  = r_done & r_moved;
    matrix = r_matrix;
    score  = r_score;
    win    = r_win;
    lose   = r_lose;
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_matrix    <= '0;
      r_lfsr      <= LFSR_SEED;
      r_score     <= '0;
      r_win       <= 1'b0;
      r_lose      <= 1'b0;
      r_done      <= 1'b0;
      r_moved     <= 1'b0;
      r_initing   <= 1'b1;
      r_dir       <= '0;
      r_line      <= '0;
      r_spawn_idx <= '0;
      r_spawn_cnt <= '0;
      r_init_left <= 5'(INIT_TILES);
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
      r_done <= 1'b0;
      case (r_state)
        c_S_INIT: begin
          if (r_init_left != 5'd0) begin
            r_init_left <= r_init_left - 5'd1;
            r_spawn_idx <= r_lfsr[3:0];
            r_spawn_cnt <= '0;
          end
        end
        c_S_IDLE: begin
          if (load_valid) begin
            r_matrix <= load_matrix;
            r_score  <= '0;
            r_moved  <= 1'b0;
          end else if (dir_valid) begin
            r_dir   <= dir;
            r_line  <= '0;
            r_moved <= 1'b0;
          end
        end
        c_S_SLIDE: begin
          r_matrix <= w_slide_matrix;
          r_score  <= w_score_next;
          r_moved  <= r_moved | w_line_changed;
          r_line   <= r_line + 2'd1;
          if (r_line == 2'd3) begin
            r_spawn_idx <= r_lfsr[3:0];
            r_spawn_cnt <= '0;
          end
        end
        c_S_SPAWN: begin
          if (w_spawn_hit) begin
            r_matrix[{r_spawn_idx, 2'b00} +: 4] <= w_spawn_val;
          end else begin
            r_spawn_idx <= r_spawn_idx + 4'd1;
            r_spawn_cnt <= r_spawn_cnt + 4'd1;
          end
        end
        c_S_CHECK: begin
          r_lose    <= ~w_has_zero & ~w_has_pair;
          r_win     <= r_win | w_has_win;
          r_done    <= ~r_initing;
          r_initing <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_game_move_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_move_engine
// Purpose  : Self-checking bench for game_move_engine. Each driven command
//            pushes its expected outcome; the done monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_move_engine;

  localparam logic [1:0] c_UP = 2'd0, c_DOWN = 2'd1, c_LEFT = 2'd2, c_RIGHT = 2'd3;

  logic        clk, rst_n, dir_valid, load_valid;
  logic [1:0]  dir;
  logic [63:0] load_matrix;
  logic [63:0] matrix;
  logic        busy, done, moved, win, lose;
  logic [19:0] score;

  game_move_engine dut (
    .clk(clk), .rst_n(rst_n), .dir_valid(dir_valid), .dir(dir),
    .load_valid(load_valid), .load_matrix(load_matrix), .matrix(matrix),
    .busy(busy), .done(done), .moved(moved), .score(score), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] mat;
    logic        spawn;
    logic [19:0] score;
    logic        mv, wn, ls;
    int          lat_min, lat_max, acc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0, n_fail = 0, cyc = 0, n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] m, input logic sp, input logic [19:0] s,
                              input logic mv, input logic wn, input logic ls,
                              input int lmin, input int lmax);
    exp_t e;
    e.mat = m; e.spawn = sp; e.score = s; e.mv = mv; e.wn = wn; e.ls = ls;
    e.lat_min = lmin; e.lat_max = lmax; e.acc = 0;
    return e;
  endfunction

  // Done monitor / scoreboard consumer
  exp_t       m_e;
  int         m_lat, m_nd, m_bad;
  logic [3:0] m_g, m_x;
  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        check("done_without_cmd", done, 0);
      end else begin
        m_e   = sb.pop_front();
        m_lat = cyc - m_e.acc + 1;
        if (m_e.lat_min == m_e.lat_max) check("latency", m_lat, m_e.lat_min);
        else check("latency_range", (m_lat >= m_e.lat_min && m_lat <= m_e.lat_max), 1);
        if (m_e.spawn) begin
          m_nd = 0; m_bad = 0;
          for (int i = 0; i < 16; i++) begin
            m_g = matrix[4*i +: 4];
            m_x = m_e.mat[4*i +: 4];
            if (m_g != m_x) begin
              m_nd++;
              if (m_x != 4'd0 || !(m_g == 4'd1 || m_g == 4'd2)) m_bad++;
            end
          end
          check("spawn_cells", m_nd, 1);
          check("spawn_value", m_bad, 0);
        end else begin
          check("matrix", matrix, m_e.mat);
        end
        check("score", score, m_e.score);
        check("moved", moved, m_e.mv);
        check("win", win, m_e.wn);
        check("lose", lose, m_e.ls);
      end
    end
  end

  task automatic send(input logic lv, input logic dv, input logic [63:0] lm,
                      input logic [1:0] d, input exp_t e);
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 300) begin @(negedge clk); t++; end
    check("idle_wait", busy, 0);
    e.acc = cyc + 1;
    sb.push_back(e);
    load_valid = lv; load_matrix = lm; dir_valid = dv; dir = d;
    @(posedge clk); #1;
    load_valid = 0; dir_valid = 0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin @(negedge clk); t++; end
    check("drain", sb.size(), 0);
  endtask

  task automatic do_reset();
    int t, cnt, bad, snap;
    rst_n = 0;
    sb.delete();
    #1;
    check("rst_matrix", matrix, 64'd0);
    check("rst_score", score, 20'd0);
    check("rst_flags", {busy, done, moved, win, lose}, 5'b10000);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    snap = n_done;
    t = 0;
    while (busy && t < 100) begin @(negedge clk); t++; end
    check("init_busy", busy, 0);
    cnt = 0; bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (matrix[4*i +: 4] != 4'd0) begin
        cnt++;
        if (matrix[4*i +: 4] > 4'd2) bad++;
      end
    end
    check("init_tiles", cnt, 2);
    check("init_values", bad, 0);
    check("init_no_done", n_done - snap, 0);
  endtask

  initial begin
    int snap;
    clk = 0; rst_n = 1; dir_valid = 0; load_valid = 0; dir = 0; load_matrix = 0;
    #1;
    do_reset();

    // Column 0 all ones, slide up
    send(1, 0, 64'h1111, c_UP, mk(64'h1111, 0, 0, 0, 0, 0, 2, 2));
    send(0, 1, 0, c_UP, mk(64'h0022, 1, 20'd8, 1, 0, 0, 7, 22));
    // Row 0 = [1,1,2,0], slide left
    send(1, 0, 64'h0000_0002_0001_0001, c_UP, mk(64'h0000_0002_0001_0001, 0, 0, 0, 0, 0, 2, 2));
    send(0, 1, 0, c_LEFT, mk(64'h0000_0000_0002_0002, 1, 20'd4, 1, 0, 0, 7, 22));
    // Row 0 = [2,0,0,2], slide right -> 3 at column 3
    send(1, 0, 64'h0002_0000_0000_0002, c_UP, mk(64'h0002_0000_0000_0002, 0, 0, 0, 0, 0, 2, 2));
    send(0, 1, 0, c_RIGHT, mk(64'h0003_0000_0000_0000, 1, 20'd8, 1, 0, 0, 7, 22));
    // Column 0 = [1,1,2,0], slide down
    send(1, 0, 64'h0211, c_UP, mk(64'h0211, 0, 0, 0, 0, 0, 2, 2));
    send(0, 1, 0, c_DOWN, mk(64'h2200, 1, 20'd4, 1, 0, 0, 7, 22));
    // Left-packed, no equal pairs: no move left or up; strobes while busy ignored
    send(1, 0, 64'h0000_0000_5432_4321, c_UP, mk(64'h0000_0000_5432_4321, 0, 0, 0, 0, 0, 2, 2));
    send(0, 1, 0, c_LEFT, mk(64'h0000_0000_5432_4321, 0, 0, 0, 0, 0, 6, 6));
    drain();
    snap = n_done;
    send(0, 1, 0, c_UP, mk(64'h0000_0000_5432_4321, 0, 0, 0, 0, 0, 6, 6));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); dir_valid = 1; dir = c_RIGHT;
    end
    @(negedge clk); dir_valid = 0;
    drain();
    repeat (30) @(negedge clk);
    check("single_done", n_done - snap, 1);
    // Checkerboard: lose; command still completes with moved=0
    send(1, 0, 64'h1212_2121_1212_2121, c_UP, mk(64'h1212_2121_1212_2121, 0, 0, 0, 0, 1, 2, 2));
    send(0, 1, 0, c_LEFT, mk(64'h1212_2121_1212_2121, 0, 0, 0, 0, 1, 6, 6));
    // Simultaneous load and dir: load wins
    drain();
    snap = n_done;
    send(1, 1, 64'h1111, c_RIGHT, mk(64'h1111, 0, 0, 0, 0, 0, 2, 2));
    drain();
    repeat (30) @(negedge clk);
    check("load_wins_one_done", n_done - snap, 1);
    // 10+10 -> 11: win, score 2048; win sticky across load
    send(1, 0, 64'h0000_0000_000A_000A, c_UP, mk(64'h0000_0000_000A_000A, 0, 0, 0, 0, 0, 2, 2));
    send(0, 1, 0, c_LEFT, mk(64'h0000_0000_0000_000B, 1, 20'd2048, 1, 1, 0, 7, 22));
    send(1, 0, 64'h1, c_UP, mk(64'h1, 0, 0, 0, 1, 0, 2, 2));
    // Exponent 14 never merges
    send(1, 0, 64'h0000_0000_000E_000E, c_UP, mk(64'h0000_0000_000E_000E, 0, 0, 0, 1, 0, 2, 2));
    send(0, 1, 0, c_LEFT, mk(64'h0000_0000_000E_000E, 0, 0, 0, 1, 0, 6, 6));
    // Reset in the middle of SLIDE
    send(1, 0, 64'h1111, c_UP, mk(64'h1111, 0, 0, 0, 1, 0, 2, 2));
    send(0, 1, 0, c_UP, mk(64'h0022, 1, 20'd8, 1, 1, 0, 7, 22));
    @(posedge clk); #1;
    do_reset();
    // win cleared by reset
    send(1, 0, 64'h1111, c_UP, mk(64'h1111, 0, 0, 0, 0, 0, 2, 2));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
